// File: rtl/edge_stim_gen.sv
// Four-state stimulus driver with per-command hold and posedge/negedge counting.
// Optional macro EDGE_STIM_GEN_XZ_EN enables driving z (10) and x (11) levels.
module edge_stim_gen #(
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_level,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              cnt_clr,
    output logic [1:0]        stim,
    output logic              pos_pulse,
    output logic              neg_pulse,
    output logic [CNT_W-1:0]  pos_cnt,
    output logic [CNT_W-1:0]  neg_cnt,
    output logic              cmd_err
);

    localparam logic [1:0] LVL_0 = 2'b00;
    localparam logic [1:0] LVL_1 = 2'b01;
    localparam logic [1:0] LVL_X = 2'b11;

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [1:0]         stim_q, stim_d;
    logic               pos_q, pos_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   pos_cnt_q, pos_cnt_d;
    logic [CNT_W-1:0]   neg_cnt_q, neg_cnt_d;
    logic               err_q, err_d;
    logic               accept;
    logic [1:0]         new_level;
    logic               old_xz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            stim_q    <= LVL_X;
            pos_q     <= 1'b0;
            neg_q     <= 1'b0;
            pos_cnt_q <= '0;
            neg_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            stim_q    <= stim_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            pos_cnt_q <= pos_cnt_d;
            neg_cnt_q <= neg_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stim_d    = stim_q;
        pos_d     = 1'b0;
        neg_d     = 1'b0;
        err_d     = err_q;
        cmd_ready = (state_q == ST_IDLE);
        accept    = cmd_valid & cmd_ready;
        new_level = cmd_level;
        old_xz    = stim_q[1];

`ifndef EDGE_STIM_GEN_XZ_EN
        // z/x requests are refused: level is kept but the hold still applies.
        if (cmd_level[1]) begin
            new_level = stim_q;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stim_d = new_level;
                    pos_d  = ((stim_q == LVL_0) && (new_level != LVL_0)) ||
                             (old_xz && (new_level == LVL_1));
                    neg_d  = ((stim_q == LVL_1) && (new_level != LVL_1)) ||
                             (old_xz && (new_level == LVL_0));
`ifndef EDGE_STIM_GEN_XZ_EN
                    if (cmd_level[1]) begin
                        err_d = 1'b1;
                    end
`endif
                    if (cmd_hold != '0) begin
                        state_d = ST_HOLD;
                        hold_d  = cmd_hold;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase

        // Clear takes priority over a coincident increment.
        pos_cnt_d = cnt_clr ? '0 : pos_cnt_q + CNT_W'(pos_d);
        neg_cnt_d = cnt_clr ? '0 : neg_cnt_q + CNT_W'(neg_d);
    end

    assign stim      = stim_q;
    assign pos_pulse = pos_q;
    assign neg_pulse = neg_q;
    assign pos_cnt   = pos_cnt_q;
    assign neg_cnt   = neg_cnt_q;
`ifdef EDGE_STIM_GEN_XZ_EN
    assign cmd_err   = 1'b0;
`else
    assign cmd_err   = err_q;
`endif

endmodule
